// File: rtl/alu_cmd_interface_pkg.sv
// Shared definitions for the UART-driven ALU command interface:
// parser state encoding, error codes and default framing bytes.
package alu_cmd_interface_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_RD_OP,
    ST_RD_END,
    ST_EXEC,
    ST_WR_RES,
    ST_WR_ERR0,
    ST_WR_ERR1
  } state_t;

  localparam logic [7:0] ERR_CODE_FRAME   = 8'h01;
  localparam logic [7:0] ERR_CODE_TIMEOUT = 8'h02;

  localparam logic [7:0] DEF_START_BYTE = 8'hA5;
  localparam logic [7:0] DEF_END_BYTE   = 8'hF5;
  localparam logic [7:0] DEF_ERR_BYTE   = 8'hEE;

  // States that watch the inter-byte timeout (IDLE waits forever).
  function automatic logic is_frame_state(input state_t s);
    return (s == ST_RD_A) || (s == ST_RD_B) || (s == ST_RD_OP) || (s == ST_RD_END);
  endfunction

endpackage

// File: rtl/alu_cmd_interface_tx_kicker.sv
// Starts the UART transmitter whenever the TX FIFO holds data, keeping
// exactly one byte in flight until the transmitter reports frame done.
module tx_kicker (
  input  logic clk,
  input  logic i_rst,
  input  logic i_tx_empty,
  input  logic i_tx_done,
  output logic o_tx_start
);

  logic busy;

  // NOTE: async reset sits in the sensitivity list so the kicker is idle
  // the instant reset rises, not at the next clock edge.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      busy       <= 1'b0;
      o_tx_start <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      if (!busy && !i_tx_empty) begin
        o_tx_start <= 1'b1;
        busy       <= 1'b1;
      end else if (i_tx_done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_interface.sv
// Parses framed operand/opcode commands from the RX FIFO, drives a
// combinational ALU and queues the result (or an error frame) to the TX FIFO.
module alu_cmd_interface
  import alu_cmd_interface_pkg::*;
#(
  parameter int                 NB_DATA        = 8,
  parameter int                 NB_REG         = 32,
  parameter int                 NB_OP          = 6,
  parameter logic [NB_DATA-1:0] START_BYTE     = DEF_START_BYTE,
  parameter logic [NB_DATA-1:0] END_BYTE       = DEF_END_BYTE,
  parameter logic [NB_DATA-1:0] ERR_BYTE       = DEF_ERR_BYTE,
  parameter int                 NB_TIMEOUT     = 24,
  parameter int                 TIMEOUT_CYCLES = 10000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_empty,
  output logic               o_rd,
  output logic [NB_REG-1:0]  o_alu_a,
  output logic [NB_REG-1:0]  o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_REG-1:0]  i_alu_out,
  output logic               o_wr,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_tx_full,
  input  logic               i_tx_empty,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err
);

  localparam int                  NB_LANES  = NB_REG / NB_DATA;
  localparam int                  NB_CNT    = $clog2(NB_LANES) + 1;
  localparam logic [NB_CNT-1:0]   LAST_LANE = NB_CNT'(NB_LANES - 1);
  localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [NB_CNT-1:0]     cnt;
  logic [NB_TIMEOUT-1:0] tmo_cnt;
  logic [NB_REG-1:0]     result;
  logic [NB_DATA-1:0]    err_code;

  logic rx_state, tx_state, pop, push, timeout;

  // NOTE: pop and push are combinational on purpose: the RX FIFO is
  // first-word-fall-through and both FIFOs must see the strobe in the same
  // cycle the empty/full flag was evaluated, or a byte would be lost or doubled.
  always_comb begin
    rx_state  = (state == ST_IDLE) || is_frame_state(state);
    tx_state  = (state == ST_WR_RES) || (state == ST_WR_ERR0) || (state == ST_WR_ERR1);
    pop       = rx_state && !i_rx_empty;
    push      = tx_state && !i_tx_full;
    timeout   = is_frame_state(state) && !pop && (tmo_cnt == TMO_LAST);
    o_tx_data = '0;
    case (state)
      ST_WR_RES:  o_tx_data = result[int'(cnt)*NB_DATA +: NB_DATA];
      ST_WR_ERR0: o_tx_data = ERR_BYTE;
      ST_WR_ERR1: o_tx_data = err_code;
      default:    o_tx_data = '0;
    endcase
  end

  assign o_rd   = pop;
  assign o_wr   = push;
  assign o_err  = push && (state == ST_WR_ERR0);
  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tmo_cnt  <= '0;
      result   <= '0;
      err_code <= '0;
      o_alu_a  <= '0;
      o_alu_b  <= '0;
      o_alu_op <= '0;
    end else begin
      if (is_frame_state(state) && !pop) tmo_cnt <= tmo_cnt + 1'b1;
      else                               tmo_cnt <= '0;

      if (timeout) begin
        // Partially received operand lanes are intentionally kept.
        err_code <= NB_DATA'(ERR_CODE_TIMEOUT);
        state    <= ST_WR_ERR0;
      end else begin
        case (state)
          ST_IDLE: if (pop && i_rx_data == START_BYTE) begin
            cnt   <= '0;
            state <= ST_RD_A;
          end
          ST_RD_A: if (pop) begin
            o_alu_a[int'(cnt)*NB_DATA +: NB_DATA] <= i_rx_data;
            if (cnt == LAST_LANE) begin
              cnt   <= '0;
              state <= ST_RD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RD_B: if (pop) begin
            o_alu_b[int'(cnt)*NB_DATA +: NB_DATA] <= i_rx_data;
            if (cnt == LAST_LANE) begin
              cnt   <= '0;
              state <= ST_RD_OP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RD_OP: if (pop) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            state    <= ST_RD_END;
          end
          ST_RD_END: if (pop) begin
            if (i_rx_data == END_BYTE) begin
              state <= ST_EXEC;
            end else begin
              err_code <= NB_DATA'(ERR_CODE_FRAME);
              state    <= ST_WR_ERR0;
            end
          end
          ST_EXEC: begin
            result <= i_alu_out;
            cnt    <= '0;
            state  <= ST_WR_RES;
          end
          ST_WR_RES: if (push) begin
            if (cnt == LAST_LANE) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_WR_ERR0: if (push) state <= ST_WR_ERR1;
          ST_WR_ERR1: if (push) state <= ST_IDLE;
          default:    state <= ST_IDLE;
        endcase
      end
    end
  end

  tx_kicker u_tx_kicker (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_tx_empty (i_tx_empty),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start)
  );

endmodule

// File: tb/tb_alu_cmd_interface.sv
// Scoreboard bench: FIFO/UART/ALU models around a 32-bit instance plus a
// 16-bit instance for the narrow-width and mid-frame reset scenarios.
module tb_alu_cmd_interface;

  localparam int TMO = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: plain arithmetic on the operands.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return b;
    endcase
  endfunction

  // ---------------- 32-bit DUT ----------------
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_empty = 1'b1;
  logic        rd, wr, tx_start, busy, err;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [5:0]  alu_op;
  logic [7:0]  tx_data;
  logic        tx_full = 1'b0, tx_empty = 1'b1, tx_done = 1'b0;

  assign alu_out = ref_alu(alu_a, alu_b, alu_op);

  alu_cmd_interface #(.NB_REG(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_empty(rx_empty), .o_rd(rd),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_out(alu_out),
    .o_wr(wr), .o_tx_data(tx_data), .i_tx_full(tx_full), .i_tx_empty(tx_empty),
    .o_tx_start(tx_start), .i_tx_done(tx_done), .o_busy(busy), .o_err(err)
  );

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  bit  gap_en = 0, stall_rand = 0, tx_stall = 0;
  bit  uart_busy = 0, uart_fire = 0;
  int  uart_cnt = 0;
  int  exp_err = 0, err_seen = 0, wr_full_viol = 0, double_start = 0, rd_bad = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [5:0]  m_op = '0;

  // Input drivers, updated away from the active edge.
  always @(negedge clk) begin
    rx_empty = (rx_q.size() == 0) || (gap_en && ($urandom_range(0, 3) == 0));
    rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    tx_empty = (tx_q.size() == 0);
    tx_full  = stall_rand ? ($urandom_range(0, 2) == 0) : tx_stall;
    tx_done  = uart_fire;
  end

  // FIFO/UART models and scoreboard monitor.
  always @(posedge clk) begin
    logic [7:0] b;
    if (rd) begin
      if (rx_empty || rx_q.size() == 0) rd_bad++;
      else void'(rx_q.pop_front());
    end
    if (tx_start && uart_busy) double_start++;
    uart_fire = 0;
    if (uart_busy) begin
      if (uart_cnt == 0) begin
        uart_fire = 1;
        uart_busy = 0;
      end else begin
        uart_cnt--;
      end
    end
    if (tx_start) begin
      uart_busy = 1;
      uart_cnt  = $urandom_range(1, 5);
      if (tx_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_start_empty: start pulse with TX FIFO empty (t=%0t)", $time);
      end else begin
        b = tx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_unexpected: got %0h expected nothing (t=%0t)", b, $time);
        end else begin
          check("tx_byte", 64'(b), 64'(exp_q.pop_front()));
        end
      end
    end
    if (wr) begin
      if (tx_full) wr_full_viol++;
      tx_q.push_back(tx_data);
    end
    if (err) err_seen++;
  end

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] opb, input logic [7:0] endb);
    logic [31:0] r;
    @(negedge clk);
    push_rx(8'hA5);
    for (int i = 0; i < 4; i++) push_rx(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) push_rx(b[8*i +: 8]);
    push_rx(opb);
    push_rx(endb);
    m_a  = a;
    m_b  = b;
    m_op = opb[5:0];
    if (endb == 8'hF5) begin
      r = ref_alu(a, b, opb[5:0]);
      for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
    end else begin
      exp_q.push_back(8'hEE);
      exp_q.push_back(8'h01);
      exp_err++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (!(rx_q.size() == 0 && exp_q.size() == 0 && tx_q.size() == 0 &&
             !busy && !uart_busy && !uart_fire) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_drained"}, 64'(cyc < 20000), 64'(1));
    if (cyc >= 20000) begin
      rx_q.delete();
      exp_q.delete();
    end
  endtask

  // ---------------- 16-bit DUT ----------------
  logic        rst2 = 1'b1;
  logic [7:0]  rx2_data = '0;
  logic        rx2_empty = 1'b1;
  logic        rd2, wr2, tx2_start, busy2, err2;
  logic [15:0] alu_a2, alu_b2, alu_out2;
  logic [5:0]  alu_op2;
  logic [7:0]  tx2_data;
  logic [7:0]  got2[$];

  assign alu_out2 = 16'(ref_alu({16'h0, alu_a2}, {16'h0, alu_b2}, alu_op2));

  alu_cmd_interface #(.NB_REG(16), .TIMEOUT_CYCLES(TMO)) dut16 (
    .clk(clk), .i_rst(rst2), .i_rx_data(rx2_data), .i_rx_empty(rx2_empty), .o_rd(rd2),
    .o_alu_a(alu_a2), .o_alu_b(alu_b2), .o_alu_op(alu_op2), .i_alu_out(alu_out2),
    .o_wr(wr2), .o_tx_data(tx2_data), .i_tx_full(1'b0), .i_tx_empty(1'b1),
    .o_tx_start(tx2_start), .i_tx_done(1'b0), .o_busy(busy2), .o_err(err2)
  );

  always @(posedge clk) if (wr2) got2.push_back(tx2_data);

  task automatic send2(input logic [7:0] b);
    @(negedge clk);
    rx2_data  = b;
    rx2_empty = 1'b0;
    @(negedge clk);
    rx2_empty = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    logic [7:0]  opb, endb, j;
    logic [5:0]  ops[5];
    ops[0] = 6'h20; ops[1] = 6'h22; ops[2] = 6'h24; ops[3] = 6'h25; ops[4] = 6'h26;

    repeat (3) @(negedge clk);
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_alu_a",    64'(alu_a),    64'(0));
    check("rst_alu_b",    64'(alu_b),    64'(0));
    check("rst_alu_op",   64'(alu_op),   64'(0));
    check("rst_wr",       64'(wr),       64'(0));
    check("rst_err",      64'(err),      64'(0));
    check("rst_tx_start", 64'(tx_start), 64'(0));
    rst  = 1'b0;
    rst2 = 1'b0;
    repeat (2) @(negedge clk);

    // Reference frame: ADD of two known operands.
    send_frame(32'h44332211, 32'h88776655, 8'h20, 8'hF5);
    wait_idle("add_frame");
    check("add_alu_a",  64'(alu_a),  64'(32'h44332211));
    check("add_alu_b",  64'(alu_b),  64'(32'h88776655));
    check("add_alu_op", 64'(alu_op), 64'(6'h20));

    // Garbage ahead of a frame is discarded.
    @(negedge clk);
    push_rx(8'h00);
    push_rx(8'h13);
    send_frame(32'h44332211, 32'h88776655, 8'h20, 8'hF5);
    wait_idle("junk_prefix");

    // Bad end byte produces an error frame.
    send_frame(32'h44332211, 32'h88776655, 8'h20, 8'h00);
    wait_idle("bad_end");

    // Inter-byte timeout mid-operand; partial lane kept.
    @(negedge clk);
    push_rx(8'hA5);
    push_rx(8'h11);
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'h02);
    exp_err++;
    wait_idle("timeout");
    check("timeout_partial_a", 64'(alu_a), 64'({m_a[31:8], 8'h11}));
    send_frame(32'h00000005, 32'h00000003, 8'h22, 8'hF5);
    wait_idle("after_timeout");

    // TX FIFO full held during the result phase.
    tx_stall = 1;
    send_frame(32'hDEADBEEF, 32'h01020304, 8'h26, 8'hF5);
    begin
      int cyc = 0;
      while (rx_q.size() != 0 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
    end
    repeat (100) @(negedge clk);
    check("stall_held_busy", 64'(busy), 64'(1));
    tx_stall = 0;
    wait_idle("tx_stall");

    // Randomized traffic with RX gaps and TX back-pressure.
    gap_en     = 1;
    stall_rand = 1;
    for (int f = 0; f < 30; f++) begin
      int nj;
      nj = $urandom_range(0, 2);
      @(negedge clk);
      for (int k = 0; k < nj; k++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        push_rx(j);
      end
      a   = $urandom;
      b   = $urandom;
      opb = {2'($urandom), ops[$urandom_range(0, 4)]};
      if ($urandom_range(0, 5) == 0) begin
        endb = 8'($urandom);
        if (endb == 8'hF5) endb = 8'h00;
      end else begin
        endb = 8'hF5;
      end
      send_frame(a, b, opb, endb);
    end
    wait_idle("random");
    gap_en     = 0;
    stall_rand = 0;
    repeat (5) @(negedge clk);
    check("last_alu_a",   64'(alu_a),  64'(m_a));
    check("last_alu_b",   64'(alu_b),  64'(m_b));
    check("last_alu_op",  64'(alu_op), 64'(m_op));
    check("err_pulses",   64'(err_seen),     64'(exp_err));
    check("wr_when_full", 64'(wr_full_viol), 64'(0));
    check("double_start", 64'(double_start), 64'(0));
    check("rd_when_empty", 64'(rd_bad),      64'(0));

    // 16-bit instance: reference frame.
    send2(8'hA5); send2(8'h34); send2(8'h12); send2(8'h78);
    send2(8'h56); send2(8'h20); send2(8'hF5);
    repeat (10) @(negedge clk);
    check("w16_count", 64'(got2.size()), 64'(2));
    if (got2.size() == 2) begin
      check("w16_byte0", 64'(got2[0]), 64'(8'hAC));
      check("w16_byte1", 64'(got2[1]), 64'(8'h68));
    end
    check("w16_alu_a", 64'(alu_a2), 64'(16'h1234));
    check("w16_alu_b", 64'(alu_b2), 64'(16'h5678));

    // 16-bit instance: reset in the middle of operand A.
    got2.delete();
    send2(8'hA5);
    send2(8'h34);
    check("w16_busy_mid", 64'(busy2), 64'(1));
    #2 rst2 = 1'b1;
    #1;
    check("w16_rst_busy",  64'(busy2),  64'(0));
    check("w16_rst_alu_a", 64'(alu_a2), 64'(0));
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    send2(8'h12); send2(8'h78); send2(8'h56); send2(8'h20); send2(8'hF5);
    repeat (30) @(negedge clk);
    check("w16_rst_no_tx",   64'(got2.size()), 64'(0));
    check("w16_rst_idle",    64'(busy2),       64'(0));
    check("w16_err_quiet",   64'(err2),        64'(0));
    check("w16_no_start",    64'(tx2_start),   64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_interface.md
ALU_CMD_INTERFACE -- requirements
Module: alu_cmd_interface

Interface
REQ-001 Parameters (name, default, meaning): NB_DATA, 8, UART byte width; NB_REG, 32, ALU operand/result width, integer multiple of NB_DATA; NB_OP, 6, ALU opcode width; START_BYTE, 8'hA5, frame start; END_BYTE, 8'hF5, frame end; ERR_BYTE, 8'hEE, error marker; NB_TIMEOUT, 24, timeout counter width; TIMEOUT_CYCLES, 10000000, inter-byte timeout in clk cycles.
REQ-002 clk  in  1  system clock, single clock domain, rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_rx_data  in  NB_DATA  RX FIFO head data, first-word-fall-through, valid while i_rx_empty=0.
REQ-005 i_rx_empty  in  1  RX FIFO empty.
REQ-006 o_rd  out  1  RX FIFO pop strobe, one cycle per consumed byte.
REQ-007 o_alu_a, o_alu_b  out  NB_REG  registered ALU operands; o_alu_op  out  NB_OP  registered opcode.
REQ-008 i_alu_out  in  NB_REG  combinational ALU result.
REQ-009 o_wr  out  1  TX FIFO push strobe; o_tx_data  out  NB_DATA  push data.
REQ-010 i_tx_full  in  1  TX FIFO full; i_tx_empty  in  1  TX FIFO empty.
REQ-011 o_tx_start  out  1  UART TX start and TX FIFO pop, one-cycle pulse; i_tx_done  in  1  UART TX frame-done tick.
REQ-012 o_busy  out  1  high when not IDLE; o_err  out  1  one-cycle pulse when an error frame is queued.

Function
REQ-013 Frame: START_BYTE, NB_REG/NB_DATA bytes of A LSB-first, same for B, one opcode byte (low NB_OP bits used), END_BYTE.
REQ-014 States: IDLE, RD_A, RD_B, RD_OP, RD_END, EXEC, WR_RES, WR_ERR0, WR_ERR1.
REQ-015 Byte consumption: in any receive state with i_rx_empty=0, o_rd=1 for that cycle and i_rx_data sampled same cycle; no pop when empty.
REQ-016 IDLE: START_BYTE -> RD_A, clear byte counter; any other byte popped and discarded.
REQ-017 RD_A/RD_B: each byte written into lane [cnt] of o_alu_a/o_alu_b; after last lane -> next state, counter cleared.
REQ-018 RD_OP: byte low bits -> o_alu_op, -> RD_END.
REQ-019 RD_END: END_BYTE -> EXEC; any other value -> WR_ERR0 with error code 8'h01.
REQ-020 EXEC: one cycle; i_alu_out captured into result register; -> WR_RES.
REQ-021 WR_RES: push result bytes LSB-first, one per cycle while i_tx_full=0; stall with o_wr=0 while full; after last byte -> IDLE.
REQ-022 WR_ERR0 pushes ERR_BYTE, WR_ERR1 pushes error code, each stalled by i_tx_full; o_err pulses on WR_ERR0 push; then -> IDLE.
REQ-023 Timeout: counter cleared on every pop and in IDLE; in RD_A..RD_END reaching TIMEOUT_CYCLES -> WR_ERR0 with code 8'h02; partial operands left unchanged.
REQ-024 TX kicker: o_tx_start pulses when i_tx_empty=0 and kicker idle; kicker busy from pulse until i_tx_done; at most one byte in flight; runs independently of parser state.
REQ-025 o_alu_a/b/op hold last values between frames.

Reset
REQ-026 i_rst=1 forces IDLE, counters 0, kicker idle, all outputs 0, operand/result registers 0, asynchronously.
REQ-027 Reset mid-frame abandons the frame; no partial result or error bytes emitted afterwards.

Structure
REQ-028 Shared package holds state encoding, error codes 8'h01/8'h02, START/END/ERR byte defaults.
REQ-029 Byte counter width = clog2(NB_REG/NB_DATA)+1, computed from parameters.
REQ-030 TX kicker is a sub-module named tx_kicker (inputs i_tx_empty, i_tx_done; output o_tx_start).

Verification
REQ-031 Frame A5 11 22 33 44 55 66 77 88 20 F5, ALU ADD=0x20 -> TX bytes 66 88 AA CC (0xCCAA8866), o_alu_a=0x44332211, o_alu_b=0x88776655.
REQ-032 Same frame but last byte 00 -> TX EE 01, o_err one pulse, no result bytes.
REQ-033 A5 11 then silence for TIMEOUT_CYCLES (set 1000) -> TX EE 02; following valid frame processed normally.
REQ-034 Bytes 00 13 before valid frame -> both discarded, only 4 result bytes emitted.
REQ-035 i_tx_full held 100 cycles during WR_RES -> o_wr low throughout, then all bytes in order, none lost; o_tx_start never pulses twice without i_tx_done.
REQ-036 NB_REG=16: A5 34 12 78 56 20 F5 -> TX AC 68 (0x68AC); reset asserted mid-operand -> o_busy=0, no TX output.
